// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Decode-stage hazard detector for a 5-stage pipeline. Computes how many
// stall cycles a load-use or branch/JR dependency needs and holds the stall
// with a down-counter. It also freezes the whole pipeline while data memory
// is busy.
// Optional feature: define HAZARD_PERF_EN to add the 32-bit StallCycles
// counter output, which counts every stalled or frozen cycle.
module hazard_stall_controller #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             DecBranch,
  input  logic             DecBranchUsesRT,
  input  logic             DecJumpReg,
  input  logic             DecUsesRS,
  input  logic             DecUsesRT,
  input  logic [REG_W-1:0] DecodeRS,
  input  logic [REG_W-1:0] DecodeRT,
  input  logic [REG_W-1:0] ExecRD,
  input  logic             ExecRegWrite,
  input  logic             ExecMemRead,
  input  logic [REG_W-1:0] MemRD,
  input  logic             MemRegWrite,
  input  logic             MemMemRead,
  input  logic             MemBusy,
  input  logic             Flush,
  output logic             StallOut,
  output logic             BubbleOut,
  output logic             FreezeOut
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      StallCycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] NEED_LL  = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] NEED_LL1 = CNT_W'(LOAD_LAT + 1);

  // A match against register 0 is never a hazard: $zero is never written.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return (src == dst) && (src != {REG_W{1'b0}});
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             br_rs_s, br_rt_s, alu_rs_s, alu_rt_s;
  logic             ex_rs_s, ex_rt_s, mem_rs_s, mem_rt_s;
  logic             mem_load_s;
  logic [CNT_W-1:0] br_ex_val_s;
  logic [CNT_W-1:0] br_rs_ex_s, br_rt_ex_s, br_rs_mem_s, br_rt_mem_s;
  logic [CNT_W-1:0] alu_rs_s_need, alu_rt_s_need;
  logic [CNT_W-1:0] need_s;
  logic             stall_s, bubble_s, freeze_s;

  // Hazard need: the worst-case stall length over every matching source.
  always_comb begin
    br_rs_s     = DecBranch | DecJumpReg;
    br_rt_s     = DecBranch & DecBranchUsesRT;
    alu_rs_s    = DecUsesRS;
    alu_rt_s    = DecUsesRT;
    ex_rs_s     = reg_match(DecodeRS, ExecRD);
    ex_rt_s     = reg_match(DecodeRT, ExecRD);
    mem_rs_s    = reg_match(DecodeRS, MemRD);
    mem_rt_s    = reg_match(DecodeRT, MemRD);
    mem_load_s  = MemRegWrite & MemMemRead;
    // Branches resolve in ID, so even an ALU result in EX costs one cycle.
    br_ex_val_s = ExecMemRead ? NEED_LL1 : CNT_ONE;

    br_rs_ex_s  = (br_rs_s && ex_rs_s && ExecRegWrite) ? br_ex_val_s : CNT_ZERO;
    br_rt_ex_s  = (br_rt_s && ex_rt_s && ExecRegWrite) ? br_ex_val_s : CNT_ZERO;
    // A non-load in MEM is forwarded to the comparator, so only loads stall.
    br_rs_mem_s = (br_rs_s && mem_rs_s && mem_load_s) ? NEED_LL : CNT_ZERO;
    br_rt_mem_s = (br_rt_s && mem_rt_s && mem_load_s) ? NEED_LL : CNT_ZERO;
    // ALU consumers only wait on a load still in EX; everything else forwards.
    alu_rs_s_need = (alu_rs_s && ex_rs_s && ExecMemRead) ? NEED_LL : CNT_ZERO;
    alu_rt_s_need = (alu_rt_s && ex_rt_s && ExecMemRead) ? NEED_LL : CNT_ZERO;

    need_s = max_cnt(max_cnt(max_cnt(br_rs_ex_s, br_rt_ex_s),
                             max_cnt(br_rs_mem_s, br_rt_mem_s)),
                     max_cnt(alu_rs_s_need, alu_rt_s_need));
  end

  // Next-state, counter and output decode; outputs follow state and inputs
  // directly so a hazard stalls in the cycle it is detected.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    freeze_s = 1'b0;
    if (Rst) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (MemBusy) begin
            freeze_s = 1'b1;
            state_d  = ST_FREEZE;
          end else if (Flush) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (need_s != CNT_ZERO) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
            cnt_d    = need_s - CNT_ONE;
            state_d  = (need_s > CNT_ONE) ? ST_STALL : ST_IDLE;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        ST_STALL: begin
          if (MemBusy) begin
            // Memory freeze overrides everything; the remaining count waits.
            stall_s  = 1'b1;
            freeze_s = 1'b1;
          end else if (Flush) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
            if (cnt_q <= CNT_ONE) begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ST_FREEZE: begin
          freeze_s = 1'b1;
          if (MemBusy) begin
            state_d = ST_FREEZE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and stall counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign StallOut  = stall_s;
  assign BubbleOut = bubble_s;
  assign FreezeOut = freeze_s;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of cycles spent stalled or frozen.
  always_comb begin
    if ((stall_s || freeze_s) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Performance counter register, cleared by reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign StallCycles = perf_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller. Three instances run side by
// side with LOAD_LAT = 1, 2, 3 on shared inputs; each scenario checks one of
// them. Expected outputs are queued when a cycle is driven and popped at the
// following falling edge.
module tb_hazard_stall_controller;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       DecBranch, DecBranchUsesRT, DecJumpReg, DecUsesRS, DecUsesRT;
  logic [4:0] DecodeRS, DecodeRT, ExecRD, MemRD;
  logic       ExecRegWrite, ExecMemRead, MemRegWrite, MemMemRead;
  logic       MemBusy, Flush;
  logic [2:0] stall_w, bubble_w, freeze_w;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_w [3];
`endif

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_stall_controller #(.REG_W(5), .LOAD_LAT(g + 1), .CNT_W(4)) u_dut (
      .Clk(Clk), .Rst(Rst),
      .DecBranch(DecBranch), .DecBranchUsesRT(DecBranchUsesRT),
      .DecJumpReg(DecJumpReg), .DecUsesRS(DecUsesRS), .DecUsesRT(DecUsesRT),
      .DecodeRS(DecodeRS), .DecodeRT(DecodeRT),
      .ExecRD(ExecRD), .ExecRegWrite(ExecRegWrite), .ExecMemRead(ExecMemRead),
      .MemRD(MemRD), .MemRegWrite(MemRegWrite), .MemMemRead(MemMemRead),
      .MemBusy(MemBusy), .Flush(Flush),
      .StallOut(stall_w[g]), .BubbleOut(bubble_w[g]), .FreezeOut(freeze_w[g])
`ifdef HAZARD_PERF_EN
      , .StallCycles(perf_w[g])
`endif
    );
  end

  typedef struct {
    string       tag;
    int          sel;
    int          kind;   // 0: {Stall,Bubble,Freeze}, 1: StallCycles
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] mon_got;
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pop every expectation queued for this cycle and compare it.
  always @(negedge Clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (mon_e.kind == 0) begin
        mon_got = {29'd0, stall_w[mon_e.sel], bubble_w[mon_e.sel], freeze_w[mon_e.sel]};
      end else begin
`ifdef HAZARD_PERF_EN
        mon_got = perf_w[mon_e.sel];
`else
        mon_got = 32'd0;
`endif
      end
      check_val(mon_e.tag, mon_got, mon_e.val);
    end
  end

  // Queue expected {Stall,Bubble,Freeze} for the cycle now driven, then advance.
  task automatic step(input string tag, input int sel, input logic [2:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.kind = 0; e.val = {29'd0, exp};
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic perf_chk(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.kind = 1; e.val = exp;
    sb_q.push_back(e);
  endtask

  task automatic clr();
    DecBranch = 1'b0; DecBranchUsesRT = 1'b0; DecJumpReg = 1'b0;
    DecUsesRS = 1'b0; DecUsesRT = 1'b0;
    DecodeRS = 5'd0; DecodeRT = 5'd0; ExecRD = 5'd0; MemRD = 5'd0;
    ExecRegWrite = 1'b0; ExecMemRead = 1'b0; MemRegWrite = 1'b0; MemMemRead = 1'b0;
    MemBusy = 1'b0; Flush = 1'b0;
  endtask

  task automatic gap(input int sel);
    clr();
    for (int i = 0; i < 6; i++) step("idle", sel, 3'b000);
  endtask

  task automatic ex_load(input logic [4:0] rd);
    ExecRD = rd; ExecRegWrite = 1'b1; ExecMemRead = 1'b1;
  endtask

  initial begin
    clr();
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    // Reset dominates a live hazard on every instance.
    DecBranch = 1'b1; DecodeRS = 5'd8; ex_load(5'd8);
    step("rst_ll1", 0, 3'b000);
    step("rst_ll2", 1, 3'b000);
    step("rst_ll3", 2, 3'b000);
    Rst = 1'b0;
    gap(0);

    // beq RS=8 vs lw RD=8 in EX, LOAD_LAT=1: two stall cycles.
    DecBranch = 1'b1; DecodeRS = 5'd8; ex_load(5'd8);
    step("beq_lw_c1", 0, 3'b110);
    step("beq_lw_c2", 0, 3'b110);
    clr();
    step("beq_lw_end", 0, 3'b000);
    gap(0);

    // beq RT dependency (uses RT), LOAD_LAT=1: two stall cycles.
    DecBranch = 1'b1; DecBranchUsesRT = 1'b1; DecodeRS = 5'd1; DecodeRT = 5'd7; ex_load(5'd7);
    step("beq_rt_c1", 0, 3'b110);
    step("beq_rt_c2", 0, 3'b110);
    clr();
    step("beq_rt_end", 0, 3'b000);
    gap(0);

    // beq vs ALU result in EX: one stall cycle.
    DecBranch = 1'b1; DecodeRS = 5'd5; ExecRD = 5'd5; ExecRegWrite = 1'b1;
    step("beq_alu_c1", 0, 3'b110);
    clr();
    step("beq_alu_end", 0, 3'b000);
    gap(0);

    // add RT=9 vs lw RD=9 in EX, LOAD_LAT=1: one stall cycle.
    DecUsesRS = 1'b1; DecUsesRT = 1'b1; DecodeRS = 5'd2; DecodeRT = 5'd9; ex_load(5'd9);
    step("add_lw_c1", 0, 3'b110);
    clr();
    step("add_lw_end", 0, 3'b000);
    gap(0);

    // Same with register 0: never a hazard.
    DecUsesRS = 1'b1; DecUsesRT = 1'b1; DecodeRS = 5'd2; DecodeRT = 5'd0; ex_load(5'd0);
    step("add_r0_c1", 0, 3'b000);
    step("add_r0_c2", 0, 3'b000);
    gap(0);

    // jr RS=31 vs lw RD=31, LOAD_LAT=3: four stall cycles.
    DecJumpReg = 1'b1; DecodeRS = 5'd31; ex_load(5'd31);
    step("jr_lw_c1", 2, 3'b110);
    step("jr_lw_c2", 2, 3'b110);
    step("jr_lw_c3", 2, 3'b110);
    step("jr_lw_c4", 2, 3'b110);
    clr();
    step("jr_lw_end", 2, 3'b000);
    gap(2);

    // Same with MemBusy for two cycles mid-stall: six stalled, two frozen.
    DecJumpReg = 1'b1; DecodeRS = 5'd31; ex_load(5'd31);
    step("jr_busy_c1", 2, 3'b110);
    clr();
    step("jr_busy_c2", 2, 3'b110);
    MemBusy = 1'b1;
    step("jr_busy_f1", 2, 3'b101);
    step("jr_busy_f2", 2, 3'b101);
    MemBusy = 1'b0;
    step("jr_busy_c3", 2, 3'b110);
    step("jr_busy_c4", 2, 3'b110);
    step("jr_busy_end", 2, 3'b000);
    gap(2);

    // beq RS=4 vs ALU result in MEM: forwarded, no stall.
    DecBranch = 1'b1; DecodeRS = 5'd4; MemRD = 5'd4; MemRegWrite = 1'b1;
    step("beq_memalu", 1, 3'b000);
    gap(1);

    // beq RS=4 vs lw in MEM, LOAD_LAT=2: two stall cycles.
    DecBranch = 1'b1; DecodeRS = 5'd4; MemRD = 5'd4; MemRegWrite = 1'b1; MemMemRead = 1'b1;
    step("beq_memlw_c1", 1, 3'b110);
    step("beq_memlw_c2", 1, 3'b110);
    clr();
    step("beq_memlw_end", 1, 3'b000);
    gap(1);

    // Reset in the second cycle of a four-cycle stall.
    DecJumpReg = 1'b1; DecodeRS = 5'd31; ex_load(5'd31);
    step("rst_mid_c1", 2, 3'b110);
    Rst = 1'b1;
    step("rst_mid_c2", 2, 3'b000);
    Rst = 1'b0;
    clr();
    step("rst_mid_c3", 2, 3'b000);
    step("rst_mid_c4", 2, 3'b000);
    gap(2);

    // Flush in the second cycle drops the stall immediately.
    DecJumpReg = 1'b1; DecodeRS = 5'd31; ex_load(5'd31);
    step("flush_c1", 2, 3'b110);
    Flush = 1'b1;
    step("flush_c2", 2, 3'b000);
    clr();
    step("flush_c3", 2, 3'b000);
    step("flush_c4", 2, 3'b000);
    gap(2);

    // MemBusy beats Flush; the held count then resumes.
    DecJumpReg = 1'b1; DecodeRS = 5'd31; ex_load(5'd31);
    step("busyflush_c1", 2, 3'b110);
    clr();
    MemBusy = 1'b1; Flush = 1'b1;
    step("busyflush_f", 2, 3'b101);
    MemBusy = 1'b0; Flush = 1'b0;
    step("busyflush_c2", 2, 3'b110);
    step("busyflush_c3", 2, 3'b110);
    step("busyflush_c4", 2, 3'b110);
    step("busyflush_end", 2, 3'b000);
    gap(2);

    // Freeze from IDLE ignores hazards; the hazard is seen after FREEZE.
    Rst = 1'b1;
    step("perf_rst", 0, 3'b000);
    Rst = 1'b0;
    perf_chk("perf_zero", 0, 32'd0);
    step("perf_idle", 0, 3'b000);
    MemBusy = 1'b1; DecBranch = 1'b1; DecodeRS = 5'd8; ex_load(5'd8);
    step("frz_c1", 0, 3'b001);
    step("frz_c2", 0, 3'b001);
    MemBusy = 1'b0;
    step("frz_c3", 0, 3'b001);
    step("frz_stall_c1", 0, 3'b110);
    step("frz_stall_c2", 0, 3'b110);
    clr();
    step("frz_end", 0, 3'b000);
`ifdef HAZARD_PERF_EN
    perf_chk("perf_five", 0, 32'd5);
`endif
    step("perf_hold", 0, 3'b000);
    Rst = 1'b1;
    step("perf_rst2", 0, 3'b000);
    Rst = 1'b0;
`ifdef HAZARD_PERF_EN
    perf_chk("perf_cleared", 0, 32'd0);
`endif
    step("final_idle", 0, 3'b000);

    @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
